// File: rtl/leiwand_rv32_wb_uart_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leiwand_rv32_wb_uart_tx_if : Wishbone responder bus bundle for the UART TX
// Revision: 1.0
// ---------------------------------------------------------------------------
interface leiwand_rv32_wb_uart_tx_if #(
  parameter int MEM_WIDTH = 32
);
  logic [1:0]           wb_addr;
  logic [MEM_WIDTH-1:0] wb_data_in;
  logic [MEM_WIDTH-1:0] wb_data_out;
  logic                 wb_we;
  logic                 wb_stb;
  logic                 wb_cyc;
  logic                 wb_ack;
  logic                 wb_stall;

  modport master (
    output wb_addr, wb_data_in, wb_we, wb_stb, wb_cyc,
    input  wb_data_out, wb_ack, wb_stall
  );

  modport slave (
    input  wb_addr, wb_data_in, wb_we, wb_stb, wb_cyc,
    output wb_data_out, wb_ack, wb_stall
  );
endinterface
`default_nettype wire

// File: rtl/leiwand_rv32_wb_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leiwand_rv32_wb_uart_tx : Wishbone UART transmitter, FIFO-buffered 8N1
// Revision: 1.0
// ---------------------------------------------------------------------------
module leiwand_rv32_wb_uart_tx #(
  parameter int          MEM_WIDTH   = 32,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  leiwand_rv32_wb_uart_tx_if.slave  wb,
  output logic                      tx
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Level is 0..FIFO_DEPTH, and FIFO_DEPTH may be 256, so nine bits always.
  localparam int c_lvl_w = 9;
  localparam logic [c_lvl_w-1:0] c_depth = c_lvl_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 r_ovf;
  logic [15:0]          r_div;
  state_t               r_state;
  logic [15:0]          r_cnt;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 r_ack;
  logic [MEM_WIDTH-1:0] r_rdata;

  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [MEM_WIDTH-1:0] w_status;
  logic [MEM_WIDTH-1:0] w_rdata;

  assign w_acc   = wb.wb_stb & wb.wb_cyc;
  assign w_wr    = w_acc & wb.wb_we;
  assign w_rd    = w_acc & ~wb.wb_we;
  assign w_full  = (r_level == c_depth);
  assign w_empty = (r_level == '0);
  // FULL uses the pre-edge level, so a same-cycle pop never rescues a push.
  assign w_push  = w_wr & (wb.wb_addr == 2'd0) & ~w_full;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty;

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_full;
    w_status[1]    = w_empty;
    w_status[2]    = (r_state != ST_IDLE);
    w_status[3]    = r_ovf;
    w_status[15:8] = r_level[7:0];
    w_rdata        = '0;
    case (wb.wb_addr)
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata[15:0] = r_div;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= w_rd ? w_rdata : '0;
      if (w_wr) begin
        case (wb.wb_addr)
          2'd0:    if (w_full) r_ovf <= 1'b1;
          2'd1:    if (wb.wb_data_in[3]) r_ovf <= 1'b0;
          2'd2:    r_div <= wb.wb_data_in[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wb.wb_data_in[7:0];
  end

  // Every bit period reloads from the live divisor, so divisor writes land
  // on the next bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_cnt   <= r_div;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == '0) begin
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_cnt   <= r_div;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= r_div;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
      endcase
    end
  end

  assign tx             = r_tx;
  assign wb.wb_ack      = r_ack;
  assign wb.wb_data_out = r_rdata;
  assign wb.wb_stall    = 1'b0;

endmodule
`default_nettype wire

// File: doc/leiwand_rv32_wb_uart_tx.md
# leiwand_rv32_wb_uart_tx

Wishbone responder peripheral that accepts bytes from the core through a small register file, buffers them in a FIFO, and serializes them as 8N1 UART frames on `tx`. It sits on the SoC Wishbone bus next to internal SRAM/ROM. The interconnect gates `wb_stb` by address decode and ORs `wb_data_out`, `wb_ack` and `wb_stall` across all responders.

## Interface
- `MEM_WIDTH`, 32: Wishbone data width.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..256.
- `DEFAULT_DIV`, 16'd433: reset value of DIVISOR; clocks per bit = DIV+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_addr` in 2: word index; the interconnect slices byte address bits [3:2].
- `wb_data_in` in MEM_WIDTH: write data from the initiator.
- `wb_data_out` out MEM_WIDTH: read data; zero except in ack cycles of reads.
- `wb_we` in 1: write enable.
- `wb_stb` in 1: strobe, already address-qualified.
- `wb_cyc` in 1: bus cycle valid.
- `wb_ack` out 1: one-cycle acknowledge.
- `wb_stall` out 1: tied 0.
- `tx` out 1: serial output, idle high.

## Operation
- Register map (`wb_addr`):
  - 0 TXDATA, write-only. A write pushes `wb_data_in[7:0]` into the FIFO. A write when full is dropped and sets OVERFLOW. Reads return 0.
  - 1 STATUS, read-only except bit 3.
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVERFLOW (sticky), bits[15:8] FIFO level; other bits 0.
    - Writing 1 to bit3 clears OVERFLOW. Other write bits are ignored.
  - 2 DIVISOR: R/W, bits[15:0]; upper bits read 0 and are ignored on write.
  - 3: reserved. Acked, reads 0, writes ignored.
- Access acceptance: `wb_stb & wb_cyc` accepts an access every cycle; there is no stall. Back-to-back accesses are legal.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH; level counter 0..FIFO_DEPTH.
  - FULL is evaluated on the pre-edge level. A push while full is rejected even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: level unchanged, both succeed.
- Transmit FSM: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, load baud counter with DIVISOR, drive tx=0, go to START. Otherwise tx=1.
  - START: at baud-counter zero, drive bit0, bit index 0, go to DATA.
  - DATA: LSB first. At each baud-counter zero, advance bit. After bit7's period, drive tx=1 and go to STOP.
  - STOP: one bit period of tx=1, then go to IDLE.
  - IDLE always lasts at least one cycle. Back-to-back frames therefore have a 1-cycle gap: period = 10·(DIV+1)+1 clocks.
- Baud counter:
  - Reloads from the live DIVISOR at every bit start, then counts down to 0.
  - A DIVISOR write mid-frame takes effect from the next bit boundary.
  - DIV=0 gives 1 clock per bit.
- Reset (any time, including mid-frame), asynchronous:
  - `tx`=1, FSM=IDLE, FIFO empty with pointers 0, OVERFLOW=0, DIVISOR=DEFAULT_DIV.
  - `wb_ack`=0, `wb_data_out`=0.

## Timing
- Access accepted at edge E:
  - `wb_ack`=1 during cycle E..E+1, for exactly one cycle per accepted access.
  - Read data is registered at E and valid only while ack is high.
- Write side effects (push, OVERFLOW set/clear, DIVISOR) are applied at edge E. A STATUS read accepted at E+1 reflects them.
- First start bit: a TXDATA write to an idle, empty block accepted at edge E → the FSM pops at edge E+1 and `tx` falls after E+1.
- `tx` is registered and changes only on clock edges, except for asynchronous reset.
- Deasserting `wb_cyc` with an ack pending does not cancel the ack. The data side effect has already occurred.

## Test plan
- Reset: drive `reset`=0 mid-frame → `tx`=1 immediately; after release, STATUS reads 0x0000_0002 and DIVISOR reads 433.
- Single byte, DIV=3: write 0xA5 → `tx` low for 4 clocks, then bits 1,0,1,0,0,1,0,1 (4 clocks each), stop high for 4 clocks; frame is 40 clocks starting one edge after the write ack.
- Fill/overflow, FIFO_DEPTH=8, DIV=1000:
  - 9 back-to-back writes. The first pops at once, so writes 2–9 fill the FIFO; all 9 are acked.
  - Then a 10th write → STATUS level=8, FULL=1, OVERFLOW=1.
  - Write 0x8 to STATUS → OVERFLOW=0.
  - All accepted bytes are transmitted in order; the dropped byte never appears.
- Back-to-back frames, DIV=0: write 3 bytes → frames of 10 clocks separated by exactly 1 idle-high clock; BUSY=0 only after the last stop bit.
- Divisor change mid-frame: DIV=3, write 0xFF, write DIV=7 during bit2 → bit2 keeps 4 clocks, bit3 onward last 8 clocks.
- Bus hygiene: read reg 3, write reg 3, read TXDATA → each acked one cycle after its strobe; `wb_data_out`=0 in all non-ack cycles and in these acks; `wb_stall` is never 1.
